// File: rtl/rx_packet_arbiter_pkg.sv
// Shared definitions for the RX packet arbiter: header length field,
// FSM state encoding and USB frame size.
package rx_packet_arbiter_pkg;

  localparam int unsigned CB_LEN_LSB  = 0;
  localparam int unsigned CB_LEN_W    = 9;
  localparam int unsigned FRAME_WORDS = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } state_t;

  function automatic logic [CB_LEN_W-1:0] cb_payload_len(input logic [63:0] hdr);
    return hdr[CB_LEN_LSB +: CB_LEN_W];
  endfunction

endpackage

// File: rtl/rx_packet_arbiter_if.sv
// FIFO-side and bulk-IN-side signals of the RX packet arbiter.
// master = the arbiter, slave = FIFOs plus downstream sink.
interface rx_packet_arbiter_if #(
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned CHAN_SEL_W = 1
);
  logic [NUM_CHAN-1:0]    chan_en;
  logic [NUM_CHAN-1:0]    ph_empty;
  logic [64*NUM_CHAN-1:0] ph_data;
  logic [NUM_CHAN-1:0]    ph_rdreq;
  logic [NUM_CHAN-1:0]    cd_empty;
  logic [16*NUM_CHAN-1:0] cd_data;
  logic [NUM_CHAN-1:0]    cd_rdreq;
  logic                   out_ready;
  logic                   out_valid;
  logic [15:0]            out_data;
  logic                   out_sop;
  logic                   out_eop;
  logic [CHAN_SEL_W-1:0]  out_chan;
  logic                   len_err;
  logic [1:0]             dbg_state;

  modport master (
    input  chan_en, ph_empty, ph_data, cd_empty, cd_data, out_ready,
    output ph_rdreq, cd_rdreq, out_valid, out_data, out_sop, out_eop,
           out_chan, len_err, dbg_state
  );

  modport slave (
    output chan_en, ph_empty, ph_data, cd_empty, cd_data, out_ready,
    input  ph_rdreq, cd_rdreq, out_valid, out_data, out_sop, out_eop,
           out_chan, len_err, dbg_state
  );
endinterface

// File: rtl/rx_packet_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester after last_grant.
module rr_arbiter #(
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned CHAN_SEL_W = 1
) (
  input  logic [NUM_CHAN-1:0]   req,
  input  logic [CHAN_SEL_W-1:0] last_grant,
  output logic [CHAN_SEL_W-1:0] grant,
  output logic                  any_req
);
  int unsigned idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_CHAN; i++) begin
      idx = (32'(last_grant) + i) % NUM_CHAN;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx[CHAN_SEL_W-1:0];
      end
    end
  end
endmodule

// File: rtl/rx_packet_arbiter.sv
// Round-robin reader of per-channel header/data FIFOs producing fixed
// 256-word USB frames (header, payload, zero padding) through an output slice.
module rx_packet_arbiter
  import rx_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHAN     = 2,
  parameter int unsigned CHAN_SEL_W   = 1,
  parameter int unsigned SAMP_PER_PKT = 252,
  parameter int unsigned HDR_WORDS    = 4
) (
  input  logic             rdclk,
  input  logic             reset,
  rx_packet_arbiter_if.master bus
);
  localparam logic [8:0] FRAME_CNT = 9'(HDR_WORDS + SAMP_PER_PKT);
  localparam logic [8:0] MAX_PAY   = 9'(SAMP_PER_PKT);
  localparam logic [8:0] LAST_HDR  = 9'(HDR_WORDS - 1);

  state_t                state, state_nxt;
  logic [CHAN_SEL_W-1:0] last_grant, last_grant_nxt, gnt, gnt_nxt, arb_grant;
  logic [NUM_CHAN-1:0]   req;
  logic                  any_req;
  logic [63:0]           hdr_reg, hdr_nxt, arb_hdr;
  logic [8:0]            pay_words, pay_nxt, len_words;
  logic [8:0]            word_cnt, word_nxt, data_cnt, dcnt_nxt;
  logic                  vld_q, vld_nxt, sop_q, sop_nxt, eop_q, eop_nxt, lerr_q, lerr_nxt;
  logic [15:0]           wd_q, wd_nxt, cd_word;
  logic [CHAN_SEL_W-1:0] chan_q, chan_nxt;
  logic                  cd_none, load, ph_pop, cd_pop;

  assign req  = bus.chan_en & ~bus.ph_empty;
  assign load = !vld_q || bus.out_ready;

  rr_arbiter #(.NUM_CHAN(NUM_CHAN), .CHAN_SEL_W(CHAN_SEL_W)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  always_comb begin
    arb_hdr = '0;
    cd_word = '0;
    cd_none = 1'b1;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      if (arb_grant == CHAN_SEL_W'(c)) arb_hdr = bus.ph_data[64*c +: 64];
      if (gnt == CHAN_SEL_W'(c)) begin
        cd_word = bus.cd_data[16*c +: 16];
        cd_none = bus.cd_empty[c];
      end
    end
  end

  assign len_words = 9'((10'(cb_payload_len(arb_hdr)) + 10'd1) >> 1);

  // word_cnt counts words loaded; reaching FRAME_CNT means the eop word sits
  // in the slice, and the next load slot is the cycle it is accepted.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    hdr_nxt        = hdr_reg;
    pay_nxt        = pay_words;
    word_nxt       = word_cnt;
    dcnt_nxt       = data_cnt;
    vld_nxt        = vld_q;
    wd_nxt         = wd_q;
    sop_nxt        = sop_q;
    eop_nxt        = eop_q;
    chan_nxt       = chan_q;
    lerr_nxt       = lerr_q;
    ph_pop         = 1'b0;
    cd_pop         = 1'b0;
    if (load) begin
      vld_nxt = 1'b0;
      sop_nxt = 1'b0;
      eop_nxt = 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            ph_pop         = 1'b1;
            gnt_nxt        = arb_grant;
            last_grant_nxt = arb_grant;
            chan_nxt       = arb_grant;
            hdr_nxt        = arb_hdr;
            wd_nxt         = arb_hdr[15:0];
            vld_nxt        = 1'b1;
            sop_nxt        = 1'b1;
            word_nxt       = 9'd1;
            dcnt_nxt       = '0;
            if (len_words > MAX_PAY) begin
              pay_nxt  = MAX_PAY;
              lerr_nxt = 1'b1;
            end else begin
              pay_nxt = len_words;
            end
            state_nxt = ST_HDR;
          end
        end
        ST_HDR: begin
          wd_nxt   = hdr_reg[16*word_cnt[1:0] +: 16];
          vld_nxt  = 1'b1;
          eop_nxt  = (word_cnt == FRAME_CNT - 9'd1);
          word_nxt = word_cnt + 9'd1;
          if (word_cnt == LAST_HDR) state_nxt = (pay_words == '0) ? ST_PAD : ST_DATA;
        end
        ST_DATA: begin
          if (word_cnt == FRAME_CNT) begin
            state_nxt = ST_IDLE;
          end else if (!cd_none) begin
            cd_pop   = 1'b1;
            wd_nxt   = cd_word;
            vld_nxt  = 1'b1;
            eop_nxt  = (word_cnt == FRAME_CNT - 9'd1);
            word_nxt = word_cnt + 9'd1;
            dcnt_nxt = data_cnt + 9'd1;
            if (data_cnt + 9'd1 == pay_words && word_cnt + 9'd1 != FRAME_CNT) state_nxt = ST_PAD;
          end
        end
        ST_PAD: begin
          if (word_cnt == FRAME_CNT) begin
            state_nxt = ST_IDLE;
          end else begin
            wd_nxt   = '0;
            vld_nxt  = 1'b1;
            eop_nxt  = (word_cnt == FRAME_CNT - 9'd1);
            word_nxt = word_cnt + 9'd1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= CHAN_SEL_W'(NUM_CHAN - 1);
      gnt        <= '0;
      hdr_reg    <= '0;
      pay_words  <= '0;
      word_cnt   <= '0;
      data_cnt   <= '0;
      vld_q      <= 1'b0;
      wd_q       <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      chan_q     <= '0;
      lerr_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      hdr_reg    <= hdr_nxt;
      pay_words  <= pay_nxt;
      word_cnt   <= word_nxt;
      data_cnt   <= dcnt_nxt;
      vld_q      <= vld_nxt;
      wd_q       <= wd_nxt;
      sop_q      <= sop_nxt;
      eop_q      <= eop_nxt;
      chan_q     <= chan_nxt;
      lerr_q     <= lerr_nxt;
    end
  end

  // Pops are combinational with the load, so they are gated by reset directly.
  always_comb begin
    bus.ph_rdreq = '0;
    bus.cd_rdreq = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      bus.ph_rdreq[c] = ph_pop && !reset && (arb_grant == CHAN_SEL_W'(c));
      bus.cd_rdreq[c] = cd_pop && !reset && (gnt == CHAN_SEL_W'(c));
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = wd_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_chan  = chan_q;
  assign bus.len_err   = lerr_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_rx_packet_arbiter.sv
// Bench for rx_packet_arbiter: FIFO models, frame-level reference model,
// table-driven single frames plus round-robin, stall, random and reset sequences.
module tb_rx_packet_arbiter;
  import rx_packet_arbiter_pkg::*;

  localparam int NCH = 2;
  localparam int SPP = 252;
  localparam int FW  = FRAME_WORDS;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic [0:0]  chan;
  } wrd_t;

  typedef struct {
    int chan;
    int len;
    int exp_data;
    int exp_pad;
    bit exp_lerr;
  } vec_t;

  logic rdclk = 1'b0;
  logic reset;
  rx_packet_arbiter_if #(.NUM_CHAN(NCH), .CHAN_SEL_W(1)) bus ();

  rx_packet_arbiter #(.NUM_CHAN(NCH), .CHAN_SEL_W(1), .SAMP_PER_PKT(SPP), .HDR_WORDS(4)) dut (
    .rdclk (rdclk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 rdclk = ~rdclk;

  int checks = 0, errors = 0;
  logic [63:0] hq [NCH][$];
  logic [15:0] dq [NCH][$];
  logic [63:0] mhq [NCH][$];
  logic [15:0] mdq [NCH][$];
  wrd_t cap[$], exp[$];
  int   sop_cyc[$];
  int   ph_pops[NCH], cd_pops[NCH];
  int   cyc = 0, eop_cnt = 0, uflow = 0, stab_err = 0, excl_err = 0;
  int   m_last = NCH - 1;
  bit   m_lerr = 0;
  bit   rand_ready = 0, rand_bubble = 0;
  logic [NCH-1:0] cd_hold = '0;
  logic [NCH-1:0] ph_s, cd_s;
  logic xfer_s, prev_stall = 1'b0;
  wrd_t w_s, w_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      bus.ph_empty[c]          = (hq[c].size() == 0);
      bus.ph_data[64*c +: 64]  = (hq[c].size() != 0) ? hq[c][0] : 64'h0;
      bus.cd_empty[c]          = (dq[c].size() == 0) || cd_hold[c];
      bus.cd_data[16*c +: 16]  = (dq[c].size() != 0) ? dq[c][0] : 16'h0;
    end
  endtask

  always @(negedge rdclk) begin
    wrd_t w_now;
    w_now  = '{data: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, chan: bus.out_chan};
    ph_s   = bus.ph_rdreq;
    cd_s   = bus.cd_rdreq;
    xfer_s = !reset && bus.out_valid && bus.out_ready;
    w_s    = w_now;
    if (!reset && prev_stall && ({bus.out_valid, w_now} !== {1'b1, w_prev})) stab_err++;
    if ((ph_s != 0 && cd_s != 0) || $countones(ph_s) > 1 || $countones(cd_s) > 1) excl_err++;
    prev_stall = !reset && bus.out_valid && !bus.out_ready;
    w_prev     = w_now;
  end

  always @(posedge rdclk) begin
    logic [63:0] t64;
    logic [15:0] t16;
    #1;
    cyc++;
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (ph_s[c]) begin
          if (hq[c].size() == 0) uflow++; else t64 = hq[c].pop_front();
          ph_pops[c]++;
        end
        if (cd_s[c]) begin
          if (dq[c].size() == 0) uflow++; else t16 = dq[c].pop_front();
          cd_pops[c]++;
        end
      end
      if (xfer_s) begin
        cap.push_back(w_s);
        if (w_s.sop) sop_cyc.push_back(cyc);
        if (w_s.eop) eop_cnt++;
      end
      if (rand_ready)  bus.out_ready = ($urandom_range(0, 3) != 0);
      if (rand_bubble) cd_hold = NCH'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
    end
    refresh();
  end

  task automatic step();
    @(posedge rdclk);
    #2;
  endtask

  function automatic logic [63:0] mk_hdr(input int len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[CB_LEN_LSB +: CB_LEN_W] = CB_LEN_W'(len);
    return h;
  endfunction

  task automatic push_hdr(input int c, input logic [63:0] h);
    hq[c].push_back(h);
    mhq[c].push_back(h);
  endtask

  task automatic push_data(input int c, input logic [15:0] v);
    dq[c].push_back(v);
    mdq[c].push_back(v);
  endtask

  // Reference: one frame is header, min(ceil(len/2), SPP) payload words, zeros to FW.
  task automatic model_frame(input int c);
    logic [63:0] h;
    int pw;
    h  = mhq[c].pop_front();
    pw = (int'(h[CB_LEN_LSB +: CB_LEN_W]) + 1) / 2;
    if (pw > SPP) begin
      pw     = SPP;
      m_lerr = 1;
    end
    for (int k = 0; k < FW; k++) begin
      wrd_t w;
      w.sop  = (k == 0);
      w.eop  = (k == FW - 1);
      w.chan = 1'(c);
      if (k < 4)           w.data = h[16*k +: 16];
      else if (k < 4 + pw) w.data = mdq[c].pop_front();
      else                 w.data = 16'h0;
      exp.push_back(w);
    end
  endtask

  task automatic model_all(input logic [NCH-1:0] en);
    bit found;
    found = 1;
    while (found) begin
      found = 0;
      for (int off = 1; off <= NCH && !found; off++) begin
        int c;
        c = (m_last + off) % NCH;
        if (en[c] && mhq[c].size() > 0) begin
          model_frame(c);
          m_last = c;
          found  = 1;
        end
      end
    end
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (eop_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk({name, " frame timeout"}, 64'(eop_cnt >= n), 64'd1);
  endtask

  task automatic cmp_frames(input string name);
    int mism, first;
    mism  = 0;
    first = -1;
    chk({name, " word count"}, 64'(cap.size()), 64'(exp.size()));
    for (int i = 0; i < cap.size() && i < exp.size(); i++)
      if (cap[i] !== exp[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    if (first >= 0)
      $display("  %s: first differing word %0d got %h expected %h", name, first, cap[first], exp[first]);
    chk({name, " content"}, 64'(mism), 64'd0);
    cap.delete();
    exp.delete();
    sop_cyc.delete();
    eop_cnt = 0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, " sop/eop"},   64'({bus.out_sop, bus.out_eop}), 64'd0);
    chk({name, " out_data"},  64'(bus.out_data), 64'd0);
    chk({name, " out_chan"},  64'(bus.out_chan), 64'd0);
    chk({name, " rdreq"},     64'({bus.ph_rdreq, bus.cd_rdreq}), 64'd0);
    chk({name, " len_err"},   64'(bus.len_err), 64'd0);
    chk({name, " dbg_state"}, 64'(bus.dbg_state), 64'd0);
  endtask

  vec_t vt[6];

  initial begin
    logic [63:0] h;
    int base_ph, base_cd, k, p;

    vt[0] = '{chan: 0, len: 504, exp_data: 252, exp_pad: 0,   exp_lerr: 0};
    vt[1] = '{chan: 0, len: 10,  exp_data: 5,   exp_pad: 247, exp_lerr: 0};
    vt[2] = '{chan: 1, len: 0,   exp_data: 0,   exp_pad: 252, exp_lerr: 0};
    vt[3] = '{chan: 1, len: 1,   exp_data: 1,   exp_pad: 251, exp_lerr: 0};
    vt[4] = '{chan: 0, len: 503, exp_data: 252, exp_pad: 0,   exp_lerr: 0};
    vt[5] = '{chan: 1, len: 510, exp_data: 252, exp_pad: 0,   exp_lerr: 1};

    reset         = 1'b1;
    bus.chan_en   = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      ph_pops[c] = 0;
      cd_pops[c] = 0;
    end
    refresh();
    #1;
    chk_idle_outputs("reset");
    repeat (3) step();
    reset = 1'b0;
    step();

    // Latency: request seen in IDLE pops immediately, sop valid next cycle.
    h = mk_hdr(8);
    push_hdr(0, h);
    for (int j = 0; j < 4; j++) push_data(0, 16'(16'h0A00 + j));
    refresh();
    @(negedge rdclk);
    chk("latency ph_rdreq", 64'(bus.ph_rdreq), 64'h1);
    step();
    chk("latency valid/sop", 64'({bus.out_valid, bus.out_sop}), 64'h3);
    chk("latency data", 64'(bus.out_data), 64'(h[15:0]));
    model_all('1);
    wait_frames("latency", 1, 600);
    cmp_frames("latency");

    for (int i = 0; i < 6; i++) begin
      base_ph = ph_pops[vt[i].chan];
      base_cd = cd_pops[vt[i].chan];
      push_hdr(vt[i].chan, mk_hdr(vt[i].len));
      for (int j = 0; j < vt[i].exp_data; j++) push_data(vt[i].chan, 16'(j + 1));
      refresh();
      model_all('1);
      wait_frames($sformatf("vec%0d", i), 1, 600);
      chk($sformatf("vec%0d size", i), 64'(cap.size()), 64'(4 + vt[i].exp_data + vt[i].exp_pad));
      if (cap.size() > 0) chk($sformatf("vec%0d chan", i), 64'(cap[0].chan), 64'(vt[i].chan));
      chk($sformatf("vec%0d ph pops", i), 64'(ph_pops[vt[i].chan] - base_ph), 64'd1);
      chk($sformatf("vec%0d cd pops", i), 64'(cd_pops[vt[i].chan] - base_cd), 64'(vt[i].exp_data));
      chk($sformatf("vec%0d len_err", i), 64'(bus.len_err), 64'(vt[i].exp_lerr));
      cmp_frames($sformatf("vec%0d", i));
    end

    // Round-robin with both channels busy; frame period 256 words + 1 idle.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) begin
        push_hdr(c, mk_hdr(504));
        for (int j = 0; j < SPP; j++) push_data(c, 16'($urandom));
      end
    refresh();
    model_all('1);
    wait_frames("rr", 4, 1400);
    chk("rr sop count", 64'(sop_cyc.size()), 64'd4);
    for (int f = 1; f < 4 && f < sop_cyc.size(); f++)
      chk($sformatf("rr period %0d", f), 64'(sop_cyc[f] - sop_cyc[f-1]), 64'd257);
    cmp_frames("rr");

    // Channel 1 masked: only channel 0 is served, channel 1 stays queued.
    bus.chan_en = 2'b01;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 2; r++) begin
        push_hdr(c, mk_hdr(40));
        for (int j = 0; j < 20; j++) push_data(c, 16'($urandom));
      end
    refresh();
    model_all(2'b01);
    wait_frames("mask", 2, 800);
    repeat (20) step();
    chk("mask frames", 64'(eop_cnt), 64'd2);
    chk("mask ch1 queued", 64'(hq[1].size()), 64'd2);
    cmp_frames("mask");
    bus.chan_en = 2'b11;
    model_all('1);
    wait_frames("unmask", 2, 800);
    cmp_frames("unmask");

    // Backpressure plus ten cycles of empty data FIFO mid-payload.
    rand_ready = 1;
    base_cd = cd_pops[1];
    base_ph = ph_pops[1];
    bus.chan_en = 2'b10;
    push_hdr(1, mk_hdr(504));
    for (int j = 0; j < SPP; j++) push_data(1, 16'($urandom));
    refresh();
    model_all(2'b10);
    k = 0;
    while (cd_pops[1] - base_cd < 50 && k < 1000) begin
      step();
      k++;
    end
    cd_hold[1] = 1'b1;
    refresh();
    p = cd_pops[1];
    repeat (10) step();
    chk("hold no pops", 64'(cd_pops[1] - p), 64'd0);
    cd_hold[1] = 1'b0;
    refresh();
    wait_frames("stall", 1, 1500);
    chk("stall cd pops", 64'(cd_pops[1] - base_cd), 64'd252);
    chk("stall ph pops", 64'(ph_pops[1] - base_ph), 64'd1);
    chk("stall stability", 64'(stab_err), 64'd0);
    cmp_frames("stall");
    bus.chan_en = 2'b11;

    // Random lengths, channels, backpressure and data bubbles.
    rand_bubble = 1;
    for (int f = 0; f < 6; f++) begin
      int c, len, pw;
      c   = $urandom_range(0, NCH - 1);
      len = $urandom_range(0, 511);
      pw  = (len + 1) / 2;
      if (pw > SPP) pw = SPP;
      push_hdr(c, mk_hdr(len));
      for (int j = 0; j < pw; j++) push_data(c, 16'($urandom));
    end
    refresh();
    model_all('1);
    wait_frames("random", 6, 12000);
    cmp_frames("random");
    chk("random len_err", 64'(bus.len_err), 64'(m_lerr));
    rand_bubble = 0;
    rand_ready  = 0;
    cd_hold     = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Reset in the middle of the payload.
    base_cd = cd_pops[0];
    push_hdr(0, mk_hdr(504));
    for (int j = 0; j < SPP; j++) push_data(0, 16'(j + 1));
    refresh();
    k = 0;
    while (cd_pops[0] - base_cd < 100 && k < 600) begin
      step();
      k++;
    end
    chk("reach word 100", 64'(cd_pops[0] - base_cd), 64'd100);
    reset = 1'b1;
    #1;
    chk_idle_outputs("mid reset");
    for (int c = 0; c < NCH; c++) begin
      hq[c].delete(); dq[c].delete(); mhq[c].delete(); mdq[c].delete();
    end
    cap.delete(); exp.delete(); sop_cyc.delete();
    eop_cnt = 0;
    m_last  = NCH - 1;
    m_lerr  = 0;
    refresh();
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int c = NCH - 1; c >= 0; c--) begin
      push_hdr(c, mk_hdr(20));
      for (int j = 0; j < 10; j++) push_data(c, 16'($urandom));
    end
    refresh();
    model_all('1);
    wait_frames("post reset", 2, 800);
    cmp_frames("post reset");
    chk("post reset len_err", 64'(bus.len_err), 64'd0);

    chk("fifo underflow", 64'(uflow), 64'd0);
    chk("rdreq one-hot/exclusive", 64'(excl_err), 64'd0);
    chk("overall stability", 64'(stab_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
